// File: rtl/stall_counter_bank_if.sv
// Read port for the stall counter bank: one valid/ready request channel that carries an index,
// and one valid/ready response channel that carries the snapshot value and an error flag.
interface stall_counter_bank_if #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned IDX_WIDTH = 5
);
    logic                 rd_req_valid;
    logic                 rd_req_ready;
    logic [IDX_WIDTH-1:0] rd_req_idx;
    logic                 rd_resp_valid;
    logic                 rd_resp_ready;
    logic [CNT_WIDTH-1:0] rd_resp_data;
    logic                 rd_resp_err;

    modport master (
        output rd_req_valid, rd_req_idx, rd_resp_ready,
        input  rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err
    );

    modport slave (
        input  rd_req_valid, rd_req_idx, rd_resp_ready,
        output rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err
    );
endinterface

// File: rtl/stall_counter_bank.sv
// Saturating per-cause stall counters plus an enabled-cycle counter. A snapshot bank holds frozen
// copies, and the read port returns snapshot entries one request at a time.
module stall_counter_bank #(
    parameter int unsigned NUM_EVENTS = 16,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned IDX_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_EVENTS-1:0] event_vec,
    input  logic                  clear,
    input  logic                  snap,
    stall_counter_bank_if.slave   bus,
    output logic [NUM_EVENTS:0]   overflow
);
    localparam int unsigned NUM_CNT = NUM_EVENTS + 1;

    typedef enum logic {StIdle, StResp} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] live_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] live_d [NUM_CNT];
    logic [CNT_WIDTH-1:0] snap_q [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_q, ovf_d, inc;
    logic [CNT_WIDTH-1:0] resp_data_q, resp_sel;
    logic                 resp_err_q, idx_ok, accept;

    // Top bit is the cycle counter, which counts every enabled cycle.
    assign inc = {1'b1, event_vec} & {NUM_CNT{enable}};

    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k < NUM_CNT; k++) begin
            live_d[k] = live_q[k];
            if (clear) begin
                live_d[k] = '0;
                ovf_d[k]  = 1'b0;
            end else if (inc[k]) begin
                if (&live_q[k]) begin
                    ovf_d[k] = 1'b1;
                end else begin
                    live_d[k] = live_q[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Snapshot takes the pre-edge live values, so snap with clear is an atomic read-and-reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                live_q[k] <= '0;
                snap_q[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                live_q[k] <= live_d[k];
                if (snap) begin
                    snap_q[k] <= live_q[k];
                end
            end
            ovf_q <= ovf_d;
        end
    end

    assign idx_ok = bus.rd_req_idx <= IDX_WIDTH'(NUM_EVENTS);

    always_comb begin
        resp_sel = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (bus.rd_req_idx == IDX_WIDTH'(k)) begin
                resp_sel = snap_q[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.rd_req_valid) begin
                    accept  = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rd_resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                resp_data_q <= idx_ok ? resp_sel : '0;
                resp_err_q  <= ~idx_ok;
            end
        end
    end

    assign bus.rd_req_ready  = (state_q == StIdle) && !rst;
    assign bus.rd_resp_valid = (state_q == StResp);
    assign bus.rd_resp_data  = resp_data_q;
    assign bus.rd_resp_err   = resp_err_q;
    assign overflow          = ovf_q;
endmodule

// File: tb/tb_stall_counter_bank.sv
// Scoreboard bench for stall_counter_bank: a behavioural model predicts counters and read
// responses; a negedge monitor checks every presented response against the expected queue.
module tb_stall_counter_bank;
    localparam int NE   = 16;
    localparam int CW   = 10;
    localparam int IW   = 5;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable, clear, snap;
    logic [NE-1:0] event_vec;
    logic [NE:0]   overflow;

    always #5 clk = ~clk;

    stall_counter_bank_if #(.CNT_WIDTH(CW), .IDX_WIDTH(IW)) bus ();

    stall_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .IDX_WIDTH(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .event_vec(event_vec),
        .clear    (clear),
        .snap     (snap),
        .bus      (bus),
        .overflow (overflow)
    );

    typedef struct {
        int data;
        bit err;
    } resp_t;

    int    live_m [NE+1];
    int    snap_m [NE+1];
    bit    ovf_m  [NE+1];
    bit    outstanding;
    resp_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k <= NE; k++) begin
            live_m[k] = 0;
            snap_m[k] = 0;
            ovf_m[k]  = 1'b0;
        end
        outstanding = 1'b0;
        exp_q.delete();
    endfunction

    // Applies the rules for one clock edge using the inputs currently driven.
    function automatic void model_step();
        bit    pre_out = outstanding;
        resp_t r;
        int    i;
        if (pre_out && bus.rd_resp_ready) outstanding = 1'b0;
        if (!pre_out && bus.rd_req_valid) begin
            i = int'(bus.rd_req_idx);
            if (i <= NE) r = '{snap_m[i], 1'b0};
            else         r = '{0, 1'b1};
            exp_q.push_back(r);
            outstanding = 1'b1;
        end
        if (snap) snap_m = live_m;
        for (int k = 0; k <= NE; k++) begin
            if (clear) begin
                live_m[k] = 0;
                ovf_m[k]  = 1'b0;
            end else if (enable && (k == NE || event_vec[k])) begin
                if (live_m[k] == MAXV) ovf_m[k] = 1'b1;
                else                   live_m[k] = live_m[k] + 1;
            end
        end
    endfunction

    task automatic cycle(input bit en, input logic [NE-1:0] ev, input bit clr, input bit snp,
                         input bit rv, input logic [IW-1:0] idx, input bit rr);
        enable            = en;
        event_vec         = ev;
        clear             = clr;
        snap              = snp;
        bus.rd_req_valid  = rv;
        bus.rd_req_idx    = idx;
        bus.rd_resp_ready = rr;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic do_read(input logic [IW-1:0] idx);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, idx, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    always @(negedge clk) begin
        logic [NE:0] ovf_exp;
        for (int k = 0; k <= NE; k++) ovf_exp[k] = ovf_m[k];
        check("rd_req_ready", 64'(bus.rd_req_ready), 64'(!rst && !outstanding));
        check("rd_resp_valid", 64'(bus.rd_resp_valid), 64'(!rst && outstanding));
        check("overflow", 64'(overflow), 64'(ovf_exp));
        if (bus.rd_resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'(1), 64'(0));
            end else begin
                check("rd_resp_data", 64'(bus.rd_resp_data), 64'(exp_q[0].data));
                check("rd_resp_err", 64'(bus.rd_resp_err), 64'(exp_q[0].err));
                if (bus.rd_resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst               = 1'b1;
        enable            = 1'b0;
        event_vec         = '0;
        clear             = 1'b0;
        snap              = 1'b0;
        bus.rd_req_valid  = 1'b0;
        bus.rd_req_idx    = '0;
        bus.rd_resp_ready = 1'b0;
        model_reset();
        #1;
        check("reset_ready", 64'(bus.rd_req_ready), 64'(0));
        check("reset_valid", 64'(bus.rd_resp_valid), 64'(0));
        check("reset_data", 64'(bus.rd_resp_data), 64'(0));
        check("reset_err", 64'(bus.rd_resp_err), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Ten counted events on bit 3, snapshot, then reads.
        repeat (10) cycle(1'b1, NE'(1) << 3, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        do_read(5'd3);
        do_read(5'd16);
        do_read(5'd5);

        // Enable gating.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        repeat (4) cycle(1'b0, NE'(1), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (4) cycle(1'b1, NE'(1), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        do_read(5'd0);
        do_read(5'd16);

        // Atomic snap-and-clear, then a second snap.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        repeat (7) cycle(1'b1, NE'(1) << 2, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        do_read(5'd2);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        do_read(5'd2);

        // Saturation: drive past 2^CW-1 with bit 1 held high and random other events.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        repeat (MAXV + 40)
            cycle(1'b1, NE'($urandom) | NE'(2), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        do_read(5'd1);
        do_read(5'd16);
        do_read(5'd7);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Out-of-range read held in RESP while snap pulses.
        cycle(1'b1, NE'($urandom), 1'b0, 1'b0, 1'b1, 5'd20, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, NE'($urandom), 1'b0, 1'(i % 2), 1'b1, 5'd3, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [IW-1:0] idx;
            idx = ($urandom % 8 == 0) ? IW'($urandom_range(17, 31)) : IW'($urandom_range(0, 16));
            cycle(($urandom % 10) != 0, NE'($urandom), ($urandom % 700) == 0,
                  ($urandom % 8) == 0, ($urandom % 3) == 0, idx, ($urandom % 2) == 0);
        end

        // Reset in the middle of a read.
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, '1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
        cycle(1'b1, '1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_valid_async", 64'(bus.rd_resp_valid), 64'(0));
        check("rst_ready", 64'(bus.rd_req_ready), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        model_reset();
        enable           = 1'b0;
        snap             = 1'b0;
        bus.rd_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("ready_after_rst", 64'(bus.rd_req_ready), 64'(1));
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k <= NE; k++) do_read(IW'(k));

        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
